// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared router link constants and packet header layout.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int DATA_W  = 64;
    localparam int HOP_LSB = 48;
    localparam int HOP_W   = 8;

    localparam logic VC_EVEN = 1'b0;
    localparam logic VC_ODD  = 1'b1;

    typedef struct packed {
        logic                 vc;
        logic [6:0]           dir;
        logic [HOP_W-1:0]     hop;
        logic [HOP_LSB-1:0]   payload;
    } pkt_hdr_t;

endpackage
`default_nettype wire

// File: rtl/router_vc_slot.sv
`default_nettype none
// ============================================================================
// Module      : router_vc_slot
// Description : Single-entry virtual-channel buffer with full flag.
// Revision    : 1.0 - initial release
// ============================================================================
module router_vc_slot #(
    parameter int DATA_W = router_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              clr_i,
    output logic              full_o,
    output logic [DATA_W-1:0] data_o,
    output logic              drop_o
);
    import router_pkg::*;

    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    // A write only lands in an empty slot; a clear only frees a full one.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (wr_i && !full_q) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (clr_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign drop_o = wr_i & full_q;

endmodule
`default_nettype wire

// File: rtl/router_output_channel.sv
`default_nettype none
// ============================================================================
// Module      : router_output_channel
// Description : Two-VC transmit end of the router link; polarity selects the
//               write VC, the other VC transmits. Define ROUTER_OC_HOP_UPDATE_EN
//               to decrement the header hop count on transmit.
// Revision    : 1.0 - initial release
// ============================================================================
module router_output_channel #(
    parameter int DATA_W  = router_pkg::DATA_W,
    parameter int HOP_LSB = router_pkg::HOP_LSB,
    parameter int HOP_W   = router_pkg::HOP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_ready,
    output logic              drop,
    input  logic              down_ready,
    output logic              send,
    output logic [DATA_W-1:0] data_out
);
    import router_pkg::*;

    logic [1:0]        w_wr;
    logic [1:0]        w_clr;
    logic [1:0]        w_full;
    logic [1:0]        w_slot_drop;
    logic [DATA_W-1:0] w_buf [2];
    logic              w_txvc;
    logic [DATA_W-1:0] w_tx_data;

    logic              send_q, send_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;

    assign w_txvc = ~polarity;

    router_vc_slot #(.DATA_W(DATA_W)) u_slot_even (
        .clk    (clk),
        .reset  (reset),
        .wr_i   (w_wr[VC_EVEN]),
        .data_i (data_in),
        .clr_i  (w_clr[VC_EVEN]),
        .full_o (w_full[VC_EVEN]),
        .data_o (w_buf[VC_EVEN]),
        .drop_o (w_slot_drop[VC_EVEN])
    );

    router_vc_slot #(.DATA_W(DATA_W)) u_slot_odd (
        .clk    (clk),
        .reset  (reset),
        .wr_i   (w_wr[VC_ODD]),
        .data_i (data_in),
        .clr_i  (w_clr[VC_ODD]),
        .full_o (w_full[VC_ODD]),
        .data_o (w_buf[VC_ODD]),
        .drop_o (w_slot_drop[VC_ODD])
    );

`ifdef ROUTER_OC_HOP_UPDATE_EN
    logic [HOP_W-1:0] w_hop;
    always_comb begin
        w_tx_data = w_buf[w_txvc];
        w_hop     = w_tx_data[HOP_LSB +: HOP_W];
        if (w_hop != '0) begin
            w_tx_data[HOP_LSB +: HOP_W] = w_hop - 1'b1;
        end
    end
`else
    assign w_tx_data = w_buf[w_txvc];
`endif

    // Write and transmit always address opposite VCs, so they never collide.
    always_comb begin
        w_wr             = '0;
        w_clr            = '0;
        w_wr[polarity]   = wr_en;
        send_d           = w_full[w_txvc] & down_ready;
        w_clr[w_txvc]    = send_d;
        drop_d           = |w_slot_drop;
        data_out_d       = send_d ? w_tx_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            send_q     <= 1'b0;
            drop_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            send_q     <= send_d;
            drop_q     <= drop_d;
            data_out_q <= data_out_d;
        end
    end

    assign wr_ready = ~w_full[polarity];
    assign send     = send_q;
    assign drop     = drop_q;
    assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_router_output_channel.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_output_channel
// Description : Self-checking bench with a per-cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_output_channel;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        polarity   = 1'b0;
    logic        wr_en      = 1'b0;
    logic [63:0] data_in    = '0;
    logic        down_ready = 1'b0;
    logic        wr_ready;
    logic        drop;
    logic        send;
    logic [63:0] data_out;

    int checks = 0;
    int errors = 0;

    // Reference model state: two single-entry VCs plus expected outputs.
    logic [63:0] m_buf  [2];
    logic        m_full [2];
    logic        m_send;
    logic        m_drop;
    logic [63:0] m_data;

    router_output_channel dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .wr_ready   (wr_ready),
        .drop       (drop),
        .down_ready (down_ready),
        .send       (send),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_tx(input logic [63:0] b);
        logic [63:0] r;
        r = b;
`ifdef ROUTER_OC_HOP_UPDATE_EN
        if (b[55:48] != 8'h00) r[55:48] = b[55:48] - 8'h01;
`endif
        return r;
    endfunction

    // Model advance at each edge, compare shortly after.
    initial begin
        int p, q;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_full[0] = 1'b0; m_full[1] = 1'b0;
                m_buf[0]  = '0;   m_buf[1]  = '0;
                m_send = 1'b0; m_drop = 1'b0; m_data = '0;
            end else begin
                p = polarity ? 1 : 0;
                q = 1 - p;
                if (m_full[q] && down_ready) begin
                    m_send    = 1'b1;
                    m_data    = model_tx(m_buf[q]);
                    m_full[q] = 1'b0;
                end else begin
                    m_send = 1'b0;
                    m_data = '0;
                end
                m_drop = wr_en && m_full[p];
                if (wr_en && !m_full[p]) begin
                    m_buf[p]  = data_in;
                    m_full[p] = 1'b1;
                end
            end
            #1;
            chk("send", {63'd0, send}, {63'd0, m_send});
            chk("data_out", data_out, m_data);
            chk("drop", {63'd0, drop}, {63'd0, m_drop});
            chk("wr_ready", {63'd0, wr_ready}, {63'd0, ~m_full[polarity ? 1 : 0]});
        end
    end

    task automatic step(input logic rst, input logic pol, input logic we,
                        input logic [63:0] din, input logic dr);
        @(negedge clk);
        reset      = rst;
        polarity   = pol;
        wr_en      = we;
        data_in    = din;
        down_ready = dr;
    endtask

    logic [63:0] t2 [4];
    logic [63:0] t5_in [3];
    logic [63:0] t5_exp [3];

    initial begin
        t2[0] = 64'h6840; t2[1] = 64'hFFFF; t2[2] = 64'hC7D4; t2[3] = 64'hFFFF_FFFF;
        t5_in[0] = 64'h0003_0000_0000_1234;
        t5_in[1] = 64'h8000_0000_0000_0001;
        t5_in[2] = 64'h1234_5678_0000_0000;
`ifdef ROUTER_OC_HOP_UPDATE_EN
        t5_exp[0] = 64'h0002_0000_0000_1234;
        t5_exp[1] = 64'h8000_0000_0000_0001;
        t5_exp[2] = 64'h1233_5678_0000_0000;
`else
        t5_exp[0] = 64'h0003_0000_0000_1234;
        t5_exp[1] = 64'h8000_0000_0000_0001;
        t5_exp[2] = 64'h1234_5678_0000_0000;
`endif

        // Reset, then a single packet
        step(0, 1, 0, '0, 1);
        chk("rst_send", {63'd0, send}, 64'd0);
        chk("rst_data", data_out, 64'd0);
        step(0, 1, 0, '0, 1);
        step(1, 0, 1, 64'hFA50, 1);
        #1 chk("t1_wr_ready", {63'd0, wr_ready}, 64'd1);
        step(1, 1, 0, '0, 1);
        chk("t1_no_early_send", {63'd0, send}, 64'd0);
        step(1, 0, 0, '0, 1);
        chk("t1_send", {63'd0, send}, 64'd1);
        chk("t1_data", data_out, 64'hFA50);
        step(1, 1, 0, '0, 1);
        chk("t1_send_off", {63'd0, send}, 64'd0);

        // Back-to-back alternating writes
        for (int k = 0; k < 6; k++) begin
            step(1, (k % 2) == 1, k < 4, (k < 4) ? t2[k % 4] : 64'd0, 1);
            if (k >= 2) begin
                chk("t2_send", {63'd0, send}, 64'd1);
                chk("t2_data", data_out, t2[k - 2]);
                chk("t2_drop", {63'd0, drop}, 64'd0);
            end
        end

        // Downstream backpressure on VC1
        step(1, 1, 1, 64'hFBA34, 0);
        step(1, 0, 0, '0, 0);
        step(1, 1, 1, 64'h1111, 0);
        #1 chk("t3_wr_ready", {63'd0, wr_ready}, 64'd0);
        chk("t3_hold", {63'd0, send}, 64'd0);
        step(1, 0, 0, '0, 0);
        chk("t3_drop", {63'd0, drop}, 64'd1);
        step(1, 1, 0, '0, 0);
        chk("t3_drop_off", {63'd0, drop}, 64'd0);
        chk("t3_hold2", {63'd0, send}, 64'd0);
        step(1, 0, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        chk("t3_send", {63'd0, send}, 64'd1);
        chk("t3_data", data_out, 64'hFBA34);
        step(1, 0, 0, '0, 1);
        chk("t3_once", {63'd0, send}, 64'd0);

        // Reset with both VCs full
        step(1, 0, 1, 64'h53FDA, 0);
        step(1, 1, 1, 64'hABCDEF, 0);
        step(1, 0, 0, '0, 0);
        #1 chk("t4_full0", {63'd0, wr_ready}, 64'd0);
        step(1, 1, 0, '0, 0);
        #1 chk("t4_full1", {63'd0, wr_ready}, 64'd0);
        step(0, 0, 0, '0, 1);
        step(0, 1, 0, '0, 1);
        step(1, 0, 0, '0, 1);
        #1 chk("t4_ready0", {63'd0, wr_ready}, 64'd1);
        chk("t4_nosend0", {63'd0, send}, 64'd0);
        step(1, 1, 0, '0, 1);
        #1 chk("t4_ready1", {63'd0, wr_ready}, 64'd1);
        chk("t4_nosend1", {63'd0, send}, 64'd0);
        step(1, 0, 0, '0, 1);
        chk("t4_nosend2", {63'd0, send}, 64'd0);

        // Hop field handling
        step(1, 1, 0, '0, 1);
        step(1, 0, 1, t5_in[0], 1);
        step(1, 1, 1, t5_in[1], 1);
        step(1, 0, 1, t5_in[2], 1);
        chk("t5_hop3", data_out, t5_exp[0]);
        step(1, 1, 0, '0, 1);
        chk("t5_hop0", data_out, t5_exp[1]);
        step(1, 0, 0, '0, 1);
        chk("t5_pass", data_out, t5_exp[2]);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) != 0,
                 ($urandom_range(0, 7) != 0) ? ~polarity : polarity,
                 $urandom_range(0, 1) == 1,
                 {$urandom, $urandom},
                 $urandom_range(0, 3) != 0);
        end

        step(1, ~polarity, 0, '0, 1);
        step(1, ~polarity, 0, '0, 1);
        step(1, ~polarity, 0, '0, 1);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/router_output_channel.md
# router_output_channel

Transmit end of the router-to-router link. It holds one 64-bit packet per virtual channel (even and odd) written by the router's internal switch. Each packet is forwarded to the downstream router's input channel with a registered `send`/`data_out` pair, gated by the downstream `ready`. The link `polarity` alternates every cycle: the internal side accesses one virtual channel while the external side accesses the other.

## Interface
- `DATA_W`, 64: packet width.
- `HOP_LSB`, 48: LSB of the header hop-count field.
- `HOP_W`, 8: hop-count field width.

- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-low.
- `polarity` input 1: link phase. Internal side uses VC `polarity`; external side uses VC `~polarity`.
- `wr_en` input 1: internal switch writes `data_in` into VC `polarity`.
- `data_in` input DATA_W: packet from the switch.
- `wr_ready` output 1: combinational, `~full[polarity]`.
- `drop` output 1: registered one-cycle pulse when `wr_en` arrives while VC `polarity` is full.
- `down_ready` input 1: downstream input channel can accept a packet.
- `send` output 1: registered, `data_out` valid this cycle.
- `data_out` output DATA_W: registered packet to the downstream link.

## Operation
- State:
  - `buf[0:1]` (DATA_W each) and `full[0:1]`.
  - VC0 is the even channel; VC1 is the odd channel.
- Write, at posedge with `p = polarity`:
  - If `wr_en && !full[p]`: `buf[p] <= data_in`, `full[p] <= 1`.
  - If `wr_en && full[p]`: the packet is discarded, `buf[p]` is unchanged, and `drop <= 1`.
  - Otherwise `drop <= 0`.
- Transmit, same posedge with `q = ~polarity`:
  - If `full[q] && down_ready`: `send <= 1`, `data_out <= buf[q]` (hop-updated, see Configuration), `full[q] <= 0`.
  - Otherwise `send <= 0`, `data_out <= 0`.
- Write and transmit always target different VCs, so they can never collide on one entry. They proceed in the same cycle independently.
- `data_in[63]` is not checked against `polarity`. The VC is set by the write phase only.
- `wr_ready` deasserts for a VC only while that VC holds an untransmitted packet.
- `polarity` that does not toggle is legal: the same VCs keep their roles, and the transmit VC drains once and stays empty.

## Timing
- Reset (`reset == 0` at posedge): `full <= 2'b00`, `send <= 0`, `data_out <= 0`, `drop <= 0`, `buf` is cleared.
  - Reset mid-transfer discards both buffered packets.
  - No `send` is issued on the cycle after reset.
- Minimum latency:
  - Write at edge N (polarity p). `polarity` is ~p at edge N+1, so VC p is read.
  - `send` is high in the cycle following edge N+1: two edges from `wr_en` to `send`.
- With `down_ready` held low, the packet is held indefinitely. `send` stays 0 and the VC stays full.
- `down_ready` is sampled only on edges where the VC is the transmit VC. It is ignored when the transmit VC is empty.
- A full VC is freed at the transmit edge. The next write to it is possible one edge later, when it is again the write VC, so back-to-back throughput is one packet per VC per two cycles.

## Configuration
- `ROUTER_OC_HOP_UPDATE_EN` defined:
  - On transmit, `data_out[HOP_LSB +: HOP_W] = buf[q][HOP_LSB +: HOP_W] - 1`, saturating at 0.
  - All other bits pass unchanged.
- Not defined: `data_out = buf[q]` bit-exact.
- Write, handshake and timing are identical in both builds.

## Structure
- Shared package `router_pkg`:
  - `DATA_W`, `HOP_LSB`, `HOP_W`.
  - `VC_EVEN = 1'b0`, `VC_ODD = 1'b1`.
  - Packet header field typedef (vc bit 63, direction bits, hop field).
- One natural sub-module, `router_vc_slot`: a single-entry buffer with a `full` flag, write/clear ports and a `drop` indication.
  - Two instances: VC0 and VC1.
  - Top level holds the polarity muxing, hop update and output registers.

## Test plan
1. **Reset then single packet.** Sequence:
   - `reset = 0` for 2 cycles, then 1; `polarity` toggles; `down_ready = 1`.
   - `wr_en` with `0x0000_0000_0000_FA50` at polarity 0.
   - Expected: `wr_ready` is 1 before the write. `send = 1` and `data_out = 0xFA50` exactly two edges later, then `send = 0`. Outputs are 0 during reset.
2. **Back-to-back alternating writes.** Write `0x6840`, `0xFFFF`, `0xC7D4`, `0xFFFF_FFFF` on four consecutive edges with `down_ready = 1`.
   - Expected: the four `send` pulses appear on four consecutive cycles, in order, with no `drop`.
3. **Downstream backpressure.** Hold `down_ready = 0` for cycles 3–5 with a packet `0xFBA34` in VC1.
   - Expected: `send` stays 0 and `wr_ready` is 0 at polarity 1.
   - A second `wr_en` at polarity 1 gives `drop = 1` for one cycle, and `0xFBA34` is preserved.
   - After `down_ready` returns to 1, `0xFBA34` is sent once.
4. **Reset mid-operation.** Both VCs are full (`0x53FDA`, `0xABCDEF`) and `down_ready = 0`; assert `reset`.
   - Expected: after release, `wr_ready = 1` for both polarities and no `send` occurs with `down_ready = 1`.
5. **Hop update.** Build with `ROUTER_OC_HOP_UPDATE_EN`.
   - Packet with hop field `0x03` gives `data_out[55:48] = 0x02`.
   - Hop field `0x00` stays `0x00`.
   - Without the macro, `0x12345678_00000000` passes unchanged.
